zeroriscy_csr_arbiter: RTL and testbench

//   Shares the single CSR register-file port between the ID-stage instruction path (core) and
//   the debug unit. Core has priority; debug accesses use a req/gnt/rvalid handshake and are

---
 rtl/zeroriscy_csr_arbiter.sv | 139 +++++++++++++
 tb/tb_zeroriscy_csr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_csr_arbiter.sv
// Shares the CSR register-file port between the ID-stage core path and the debug unit.
// Optional macro CSR_ARB_STARVE_EN: debug starvation counter, FORCE state and core stall.
module zeroriscy_csr_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_csr_access_i,
  input  logic [11:0] core_csr_addr_i,
  input  logic [31:0] core_csr_wdata_i,
  input  logic [1:0]  core_csr_op_i,
  output logic [31:0] core_csr_rdata_o,
  output logic        core_stall_o,
  input  logic        csr_save_cause_i,
  input  logic        csr_restore_mret_i,
  input  logic        dbg_csr_req_i,
  input  logic        dbg_csr_we_i,
  input  logic [11:0] dbg_csr_addr_i,
  input  logic [31:0] dbg_csr_wdata_i,
  output logic        dbg_csr_gnt_o,
  output logic        dbg_csr_rvalid_o,
  output logic [31:0] dbg_csr_rdata_o,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);
  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_WRITE = 2'd1;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("zeroriscy_csr_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, FORCE, RVALID} state_e;

  state_e      state, state_nxt;
  logic        dbg_ok, gnt;
  logic [31:0] rdata_q;

`ifdef CSR_ARB_STARVE_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  logic [7:0] wait_cnt, wait_cnt_nxt;
`endif

  // rst_n in the term kills a combinational grant the moment reset asserts.
  assign dbg_ok = rst_n & dbg_csr_req_i & ~csr_save_cause_i & ~csr_restore_mret_i;

  always_comb begin
    state_nxt    = state;
    gnt          = 1'b0;
    core_stall_o = 1'b0;
`ifdef CSR_ARB_STARVE_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (dbg_ok && !core_csr_access_i) begin
          gnt       = 1'b1;
          state_nxt = RVALID;
        end else if (dbg_csr_req_i) begin
`ifdef CSR_ARB_STARVE_EN
          if (wait_cnt != 8'hFF) wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) state_nxt = FORCE;
`endif
        end else begin
`ifdef CSR_ARB_STARVE_EN
          wait_cnt_nxt = '0;
`endif
        end
      end
      FORCE: begin
`ifdef CSR_ARB_STARVE_EN
        core_stall_o = 1'b1;
        if (dbg_ok) begin
          gnt       = 1'b1;
          state_nxt = RVALID;
        end else if (!dbg_csr_req_i) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end
`else
        state_nxt = IDLE;
`endif
      end
      RVALID: begin
        state_nxt = IDLE;
`ifdef CSR_ARB_STARVE_EN
        wait_cnt_nxt = '0;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port mux: core by default, silenced while stalled, debug when granted.
  always_comb begin
    csr_access_o = core_csr_access_i;
    csr_addr_o   = core_csr_addr_i;
    csr_wdata_o  = core_csr_wdata_i;
    csr_op_o     = core_csr_op_i;
    if (state == FORCE) begin
      csr_access_o = 1'b0;
      csr_addr_o   = dbg_csr_addr_i;
      csr_wdata_o  = dbg_csr_wdata_i;
      csr_op_o     = CSR_OP_NONE;
    end
    if (gnt) begin
      csr_access_o = 1'b1;
      csr_addr_o   = dbg_csr_addr_i;
      csr_wdata_o  = dbg_csr_wdata_i;
      csr_op_o     = dbg_csr_we_i ? CSR_OP_WRITE : CSR_OP_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt) rdata_q <= csr_rdata_i;
    end
  end

`ifdef CSR_ARB_STARVE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else        wait_cnt <= wait_cnt_nxt;
  end
`endif

  assign dbg_csr_gnt_o    = gnt;
  assign dbg_csr_rvalid_o = (state == RVALID);
  assign dbg_csr_rdata_o  = rdata_q;
  assign core_csr_rdata_o = csr_rdata_i;

endmodule

// File: tb/tb_zeroriscy_csr_arbiter.sv
// Scoreboard bench for zeroriscy_csr_arbiter: directed spec scenarios plus randomized traffic
// against a stub CSR file; debug read data is predicted from an independent CSR value model.
module tb_zeroriscy_csr_arbiter;
  localparam int MAX_WAIT = 8;
  localparam logic [1:0] OP_NONE = 2'd0, OP_WRITE = 2'd1, OP_SET = 2'd2, OP_CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_access, save, mret, dbg_req, dbg_we;
  logic [11:0] core_addr, dbg_addr, csr_addr;
  logic [31:0] core_wdata, dbg_wdata, core_rdata, dbg_rdata, csr_wdata, csr_rdata;
  logic [1:0]  core_op, csr_op;
  logic        stall, gnt, rvalid, csr_access;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] csr_mem [4096];
  logic [31:0] ref_csr [logic [11:0]];

  always #5 clk = ~clk;

  zeroriscy_csr_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_csr_access_i(core_access), .core_csr_addr_i(core_addr),
    .core_csr_wdata_i(core_wdata), .core_csr_op_i(core_op),
    .core_csr_rdata_o(core_rdata), .core_stall_o(stall),
    .csr_save_cause_i(save), .csr_restore_mret_i(mret),
    .dbg_csr_req_i(dbg_req), .dbg_csr_we_i(dbg_we),
    .dbg_csr_addr_i(dbg_addr), .dbg_csr_wdata_i(dbg_wdata),
    .dbg_csr_gnt_o(gnt), .dbg_csr_rvalid_o(rvalid), .dbg_csr_rdata_o(dbg_rdata),
    .csr_access_o(csr_access), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .csr_op_o(csr_op), .csr_rdata_i(csr_rdata)
  );

  // Power-on CSR contents: mepc=0x1234, other 0x34x debug-visible regs 0x1000|addr.
  function automatic logic [31:0] init_val(input logic [11:0] a);
    if (a == 12'h341) return 32'h0000_1234;
    if (a[11:4] == 8'h34) return {20'h00001, a};
    return 32'h0;
  endfunction

  // Stub CSR file driven by the arbiter's port.
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(12'(i));
    end else if (csr_access) begin
      case (csr_op)
        OP_WRITE: csr_mem[csr_addr] <= csr_wdata;
        OP_SET:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
        OP_CLEAR: csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    if (ref_csr.exists(a)) return ref_csr[a];
    return init_val(a);
  endfunction

  // A debug access returns the value held before it; a write then replaces it.
  task automatic push_exp(input logic we, input logic [11:0] a, input logic [31:0] wd);
    exp_q.push_back(ref_rd(a));
    if (we) ref_csr[a] = wd;
  endtask

  // Monitor: rvalid must follow each grant by exactly one cycle with the predicted data.
  logic gnt_d = 1'b0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_d <= 1'b0;
      exp_q.delete();
    end else begin
      if (rvalid) begin
        if (!gnt_d || exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
        else check("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end else if (gnt_d) begin
        check("rvalid_missing", 32'd0, 32'd1);
      end
      check("core_rdata", core_rdata, csr_rdata);
      if (!gnt && !stall) begin
        check("pass_access", {31'd0, csr_access}, {31'd0, core_access});
        check("pass_addr", {20'd0, csr_addr}, {20'd0, core_addr});
        check("pass_wdata", csr_wdata, core_wdata);
        check("pass_op", {30'd0, csr_op}, {30'd0, core_op});
      end
      gnt_d <= gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_access = 0; core_addr = 0; core_wdata = 0; core_op = OP_NONE;
    save = 0; mret = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic dbg_txn(input logic we, input logic [11:0] a, input logic [31:0] wd,
                         output int lat, output logic [1:0] op_at);
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; lat = 0; op_at = OP_NONE;
    forever begin
      @(negedge clk);
      lat++;
      if (gnt) begin
        op_at = csr_op;
        push_exp(we, a, wd);
        break;
      end
      if (lat >= 20) begin
        check("gnt_timeout", 32'd0, 32'd1);
        break;
      end
      step();
    end
    step();
    dbg_req = 0;
  endtask

  // Debug read held against continuous core traffic; reports the cycle of the grant.
  task automatic starve_run(input logic [11:0] a, output logic got, output int cyc, output logic st);
    got = 0; cyc = 0; st = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = a;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (gnt) begin
        got = 1; cyc = c; st = stall;
        push_exp(1'b0, a, 32'd0);
      end else if (c <= 3) begin
        check("t3_core_op_on_port", {30'd0, csr_op}, {30'd0, OP_WRITE});
        check("t3_no_stall", {31'd0, stall}, 32'd0);
      end
      step();
      core_wdata = $urandom;
    end
  endtask

  int         lat, cyc, wt;
  logic [1:0] op_at;
  logic       got, st, busy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_csr_op", {30'd0, csr_op}, {30'd0, OP_NONE});
    check("rst_csr_access", {31'd0, csr_access}, 32'd0);
    step();
    rst_n = 1;
    step();

    // 1: uncontended debug read of mepc
    dbg_txn(1'b0, 12'h341, 32'd0, lat, op_at);
    check("t1_gnt_latency", lat, 1);
    check("t1_op_read", {30'd0, op_at}, {30'd0, OP_NONE});
    @(negedge clk);
    check("t1_rvalid", {31'd0, rvalid}, 32'd1);
    check("t1_rdata", dbg_rdata, 32'h0000_1234);
    step();

    // 2: debug write to mstatus sets MIE
    dbg_txn(1'b1, 12'h300, 32'h8, lat, op_at);
    check("t2_gnt_latency", lat, 1);
    check("t2_op_write", {30'd0, op_at}, {30'd0, OP_WRITE});
    @(negedge clk);
    check("t2_op_one_cycle", {30'd0, csr_op}, {30'd0, OP_NONE});
    check("t2_rvalid", {31'd0, rvalid}, 32'd1);
    check("t2_mstatus_mie", {31'd0, csr_mem[12'h300][3]}, 32'd1);
    step();

    // 5: save_cause blocks the grant for one cycle
    save = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 12'h342;
    @(negedge clk);
    check("t5_gnt_blocked", {31'd0, gnt}, 32'd0);
    step();
    save = 0;
    @(negedge clk);
    check("t5_gnt_next", {31'd0, gnt}, 32'd1);
    if (gnt) push_exp(1'b0, 12'h342, 32'd0);
    step();
    dbg_req = 0;
    step();

    // 3/4: continuous core traffic vs held debug request
    core_access = 1; core_addr = 12'h7C0; core_op = OP_WRITE; core_wdata = $urandom;
    starve_run(12'h343, got, cyc, st);
`ifdef CSR_ARB_STARVE_EN
    check("t4_gnt_cycle", cyc, MAX_WAIT + 1);
    check("t4_stall_at_gnt", {31'd0, st}, 32'd1);
    dbg_req = 0;
    @(negedge clk);
    check("t4_stall_released", {31'd0, stall}, 32'd0);
    step();
`else
    check("t4_never_gnt", {31'd0, got}, 32'd0);
    core_access = 0;
    @(negedge clk);
    check("t4_gnt_when_core_idle", {31'd0, gnt}, 32'd1);
    if (gnt) push_exp(1'b0, 12'h343, 32'd0);
    step();
    dbg_req = 0;
    step();
`endif

`ifdef CSR_ARB_STARVE_EN
    // 6: reset while in FORCE
    core_access = 1; save = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 12'h344;
    repeat (MAX_WAIT) step();
    @(negedge clk);
    check("t6_in_force_stall", {31'd0, stall}, 32'd1);
    check("t6_in_force_no_gnt", {31'd0, gnt}, 32'd0);
    #2 rst_n = 0;
    ref_csr.delete();
    #1;
    check("t6_rst_stall", {31'd0, stall}, 32'd0);
    check("t6_rst_gnt", {31'd0, gnt}, 32'd0);
    check("t6_rst_rvalid", {31'd0, rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    save = 0;
    starve_run(12'h344, got, cyc, st);
    check("t6_wait_cnt_cleared", cyc, MAX_WAIT + 1);
    dbg_req = 0;
    step();
    core_access = 0;
    step();
`endif

    // Reset between grant and capture aborts the access: no rvalid
    idle_inputs();
    dbg_req = 1; dbg_addr = 12'h345;
    @(negedge clk);
    check("abort_gnt", {31'd0, gnt}, 32'd1);
    #2 rst_n = 0;
    ref_csr.delete();
    #1;
    check("abort_gnt_dropped", {31'd0, gnt}, 32'd0);
    @(negedge clk);
    check("abort_no_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    dbg_req = 0;
    rst_n = 1;
    step();

    // Randomized traffic
    busy = 0; wt = 0;
    for (int c = 0; c < 400; c++) begin
      core_access = ($urandom_range(0, 99) < 50);
      core_addr   = {8'h7C, 4'($urandom)};
      core_op     = 2'($urandom);
      core_wdata  = $urandom;
      save        = ($urandom_range(0, 99) < 10);
      mret        = ($urandom_range(0, 99) < 10);
      if (!busy && $urandom_range(0, 99) < 40) begin
        busy = 1; wt = 0;
        dbg_req = 1; dbg_we = 1'($urandom);
        dbg_addr = {8'h34, 4'($urandom)}; dbg_wdata = $urandom;
      end
      @(negedge clk);
      if (busy && gnt) begin
        check("rnd_gnt_not_blocked", {31'd0, save | mret}, 32'd0);
        if (core_access) check("rnd_gnt_over_core_stalls", {31'd0, stall}, 32'd1);
        push_exp(dbg_we, dbg_addr, dbg_wdata);
        busy = 0;
      end else if (busy) begin
        wt++;
        if (wt > 200) begin
          check("rnd_gnt_timeout", 32'd0, 32'd1);
          busy = 0;
        end
      end
`ifndef CSR_ARB_STARVE_EN
      check("rnd_stall_tied_low", {31'd0, stall}, 32'd0);
`endif
      step();
      if (!busy) dbg_req = 0;
    end

    idle_inputs();
    repeat (3) step();
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
